snn_aer_decoder: RTL and testbench
==================================

// Module: snn_aer_decoder
// PURPOSE
// - Receive end of the address-event (AER) spike link: takes serialized spike events (block, neuron)
//   and rebuilds per-block synaptic input vectors for the N-neuron x T-block array, one timestep at a time.
// - Sits between the spike router and the neuron blocks; per-event weight is K_SYN from neuron_config_t.
// PARAMETERS
// - N      3  neurons per block (package default)
// - T      2  number of blocks (package default)
// - SYN_W  4  width of each per-neuron synaptic accumulator
// - K_SYN  1  increment per event (driven from neuron_config_t.K_SYN)
// PORTS
// - clk        in   1                  clock; all logic on posedge
// - reset      in   1                  asynchronous, active-high reset
// - ev_valid   in   1                  event valid
// - ev_ready   out  1                  event accepted when ev_valid & ev_ready
// - ev_addr    in   aer_addr_t         {block[BLK_W], neuron[NRN_W]}
// - tick       in   1                  timestep boundary, single-cycle pulse
// - out_valid  out  1                  per-block syn vector valid
// - out_ready  in   1                  downstream accepts out_* on out_valid & out_ready
// - out_block  out  BLK_W              block index of out_syn
// - out_syn    out  N*SYN_W            per-neuron accumulated input, neuron 0 in LSBs
// - err_addr   out  8                  saturating count of dropped out-of-range events
// - err_tick   out  8                  saturating count of ticks arriving while FLUSH is in progress
// BEHAVIOUR
// - Reset: ev_ready=0 while reset is asserted, 1 from the first cycle after release;
//   out_valid=0, out_block=0, out_syn=0, err_*=0.
// - Reset: both banks cleared, FSM=ACCUM.
// - Two accumulator banks (T*N x SYN_W). Write bank receives events; read bank is flushed.
// - ACCUM: each accepted event adds K_SYN to write_bank[block][neuron] one cycle after the handshake.
//   - The add saturates at 2^SYN_W-1.
//   - An event with neuron>=N or block>=T is accepted and dropped; err_addr is incremented.
// - tick in ACCUM:
//   - Banks swap at the end of the tick cycle; FSM -> FLUSH.
//   - An event accepted in the tick cycle lands in the OLD write bank (belongs to the ending step).
//   - An event accepted after the tick cycle lands in the new write bank.
// - FLUSH: emits blocks 0..T-1 in order from the read bank, one per out_valid & out_ready handshake.
//   - out_* hold stable while out_valid=1 and out_ready=0.
//   - Each emitted block's read-bank entries are cleared on its handshake.
//   - Minimum latency tick -> first out_valid: 1 cycle.
//   - Back-to-back blocks are possible when out_ready=1.
// - Last handshake (block T-1) -> ACCUM. Empty timesteps still emit T all-zero vectors.
// - tick during FLUSH: ignored (no swap); err_tick is incremented. Events continue into the write bank.
// - ev_ready=1 in both states, since double banking removes the need for backpressure.
//   The only exception is the FIFO option below.
// - Both error counters saturate at 255.
// CONFIGURATION
// - SNN_AER_FIFO_EN defined:
//   - A 4-entry input FIFO sits in front of the decoder. ev_ready = !fifo_full.
//   - An event enters a bank 2 cycles after acceptance.
//   - A tick is applied only once all events accepted before the tick have been drained from the FIFO.
//     For this, tick is tagged into the FIFO stream as a marker entry.
// - Undefined: no FIFO; behaviour exactly as in BEHAVIOUR.
// STRUCTURE
// - snn_pkg: add BLK_W=$clog2(T) (min 1), NRN_W=$clog2(N) (min 1), aer_addr_t packed struct
//   {block, neuron}, and typedef enum {ACCUM, FLUSH} aer_dec_state_t.
// - Sub-module snn_aer_fifo (sync FIFO, depth 4), instantiated only under SNN_AER_FIFO_EN.
// TESTING (N=3, T=2, SYN_W=4, K_SYN=1, FIFO off unless noted)
// - Events (0,1)x3 and (1,2)x1, then tick, out_ready=1:
//   -> out(block0)=syn{0,3,0}, out(block1)=syn{1,0,0} (n2..n0); err_*=0.
// - 20 events to (1,0), then tick -> block1 neuron0 = 15 (saturated); other entries 0.
// - Event (0,3) and event (2,0), then tick -> both dropped; err_addr=2; all out_syn=0.
// - Hold out_ready=0 for 5 cycles after tick; pulse tick again, send event (0,0):
//   -> out_* stable; err_tick=1; after the flush, the next tick yields block0 neuron0=1.
// - Event handshake in the same cycle as tick -> counted in the ending step.
//   An event one cycle later is counted in the next step.
// - Assert reset mid-FLUSH -> out_valid=0 immediately; the next tick emits all-zero vectors.
// - SNN_AER_FIFO_EN: 6 back-to-back events with the decoder stalled in FLUSH -> ev_ready drops after 4.
//   All accepted events are counted; none are lost.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN spike path (AER decoder and neuron-block array).
package snn_pkg;

  localparam int unsigned N     = 3;
  localparam int unsigned T     = 2;
  localparam int unsigned SYN_W = 4;
  localparam int unsigned BLK_W = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned NRN_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NE    = T * N;
  localparam int unsigned ERR_W = 8;

  typedef struct packed {
    logic [SYN_W-1:0] k_syn;
  } neuron_config_t;

  localparam neuron_config_t NEURON_CFG = '{k_syn: SYN_W'(1)};

  typedef struct packed {
    logic [BLK_W-1:0] block;
    logic [NRN_W-1:0] neuron;
  } aer_addr_t;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } aer_dec_state_t;

  // One FIFO slot: optional event followed by an optional timestep marker.
  typedef struct packed {
    logic      ev;
    logic      tick;
    aer_addr_t addr;
  } aer_fifo_ent_t;

  function automatic logic [SYN_W-1:0] sat_add(input logic [SYN_W-1:0] a,
                                               input logic [SYN_W-1:0] b);
    logic [SYN_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SYN_W] ? {SYN_W{1'b1}} : s[SYN_W-1:0];
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/snn_aer_fifo.sv
// Small synchronous FIFO buffering AER entries ahead of the decoder.
module snn_aer_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata_c,
  output logic [CW-1:0] count,
  output logic          full_c,
  output logic          empty_c
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  always_comb begin
    full_c  = (cnt_q == CW'(DEPTH));
    empty_c = (cnt_q == '0);
    push_ok = push & ~full_c;
    pop_ok  = pop & ~empty_c;
    mem_d   = mem_q;
    if (push_ok) mem_d[wptr_q] = wdata;
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    rdata_c = mem_q[rptr_q];
    count   = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/snn_aer_decoder.sv
// AER receive decoder: accumulates spike events into double-banked per-block synaptic vectors
// and flushes one timestep per tick. Optional input FIFO selected by SNN_AER_FIFO_EN.
module snn_aer_decoder
  import snn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  aer_addr_t          ev_addr,
  input  logic               tick,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_W-1:0]   out_block,
  output logic [N*SYN_W-1:0] out_syn,
  output logic [7:0]         err_addr,
  output logic [7:0]         err_tick
);

  localparam int unsigned BW = N * SYN_W;

  aer_dec_state_t      state_q, state_d;
  logic                wr_sel_q, wr_sel_d;
  logic [NE*SYN_W-1:0] bank_q [2];
  logic [NE*SYN_W-1:0] bank_d [2];
  logic                out_valid_q, out_valid_d;
  logic [BLK_W-1:0]    out_block_q, out_block_d;
  logic [BW-1:0]       out_syn_q, out_syn_d;
  logic [7:0]          err_addr_q, err_addr_d;
  logic [7:0]          err_tick_q, err_tick_d;
  logic                ev_ready_q, ev_ready_d;

  logic                core_ev, core_tick, tick_lost;
  aer_addr_t           core_addr;
  logic                ev_in_range, rd_sel;
  int unsigned         ev_idx;

`ifdef SNN_AER_FIFO_EN
  aer_fifo_ent_t fifo_wdata, fifo_rdata;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2:0]    fifo_cnt;
  logic          tick_pend_q, tick_pend_d;
  logic          ev_acc, tick_any;

  // A tick that finds the FIFO full waits in tick_pend_q; events are held off until it is queued.
  always_comb begin
    ev_acc      = ev_valid & ev_ready_q;
    tick_any    = tick | tick_pend_q;
    fifo_push   = ~fifo_full & (ev_acc | tick_any);
    fifo_wdata  = '{ev: ev_acc, tick: tick_any, addr: ev_addr};
    fifo_pop    = ~fifo_empty & (state_q == ACCUM);
    tick_pend_d = tick_any & fifo_full;
    tick_lost   = tick & tick_pend_q;
    core_ev     = fifo_pop & fifo_rdata.ev;
    core_tick   = fifo_pop & fifo_rdata.tick;
    core_addr   = fifo_rdata.addr;
    ev_ready_d  = ((fifo_cnt + 3'(fifo_push) - 3'(fifo_pop)) != 3'd4) & ~tick_pend_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_pend_q <= 1'b0;
    else       tick_pend_q <= tick_pend_d;
  end

  snn_aer_fifo #(.W($bits(aer_fifo_ent_t)), .DEPTH(4)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wdata   (fifo_wdata),
    .pop     (fifo_pop),
    .rdata_c (fifo_rdata),
    .count   (fifo_cnt),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );
`else
  always_comb begin
    core_ev    = ev_valid & ev_ready_q;
    core_tick  = tick;
    core_addr  = ev_addr;
    tick_lost  = 1'b0;
    ev_ready_d = 1'b1;
  end
`endif

  // Event accumulation, bank swap and per-block flush.
  always_comb begin
    state_d     = state_q;
    wr_sel_d    = wr_sel_q;
    bank_d      = bank_q;
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;
    out_syn_d   = out_syn_q;
    err_addr_d  = err_addr_q;
    err_tick_d  = err_tick_q;
    rd_sel      = ~wr_sel_q;
    ev_in_range = (32'(core_addr.block) < T) && (32'(core_addr.neuron) < N);
    ev_idx      = 32'(core_addr.block) * N + 32'(core_addr.neuron);

    if (core_ev) begin
      if (ev_in_range) begin
        for (int unsigned e = 0; e < NE; e++) begin
          if (ev_idx == e)
            bank_d[wr_sel_q][e*SYN_W +: SYN_W] =
              sat_add(bank_q[wr_sel_q][e*SYN_W +: SYN_W], NEURON_CFG.k_syn);
        end
      end else begin
        err_addr_d = sat_inc(err_addr_q);
      end
    end

    if (state_q == ACCUM) begin
      // Forward from bank_d so an event taken in the tick cycle is part of block 0.
      if (core_tick) begin
        wr_sel_d    = ~wr_sel_q;
        state_d     = FLUSH;
        out_valid_d = 1'b1;
        out_block_d = '0;
        out_syn_d   = bank_d[wr_sel_q][BW-1:0];
      end
    end else begin
      if (core_tick) err_tick_d = sat_inc(err_tick_q);
      if (out_valid_q && out_ready) begin
        for (int unsigned b = 0; b < T; b++) begin
          if (32'(out_block_q) == b) bank_d[rd_sel][b*BW +: BW] = '0;
        end
        if (32'(out_block_q) == T - 1) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          out_block_d = '0;
          out_syn_d   = '0;
        end else begin
          out_block_d = out_block_q + BLK_W'(1);
          for (int unsigned b = 0; b < T; b++) begin
            if (32'(out_block_q) + 1 == b) out_syn_d = bank_q[rd_sel][b*BW +: BW];
          end
        end
      end
    end

    if (tick_lost) err_tick_d = sat_inc(err_tick_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      wr_sel_q    <= 1'b0;
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
      out_syn_q   <= '0;
      err_addr_q  <= '0;
      err_tick_q  <= '0;
      ev_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_sel_q    <= wr_sel_d;
      bank_q      <= bank_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
      out_syn_q   <= out_syn_d;
      err_addr_q  <= err_addr_d;
      err_tick_q  <= err_tick_d;
      ev_ready_q  <= ev_ready_d;
    end
  end

  assign ev_ready  = ev_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign out_syn   = out_syn_q;
  assign err_addr  = err_addr_q;
  assign err_tick  = err_tick_q;

endmodule

// File: tb/tb_snn_aer_decoder.sv
// Directed self-checking bench for snn_aer_decoder (N=3, T=2, SYN_W=4, K_SYN=1).
module tb_snn_aer_decoder;
  import snn_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               ev_valid;
  logic               ev_ready;
  aer_addr_t          ev_addr;
  logic               tick;
  logic               out_valid;
  logic               out_ready;
  logic [BLK_W-1:0]   out_block;
  logic [N*SYN_W-1:0] out_syn;
  logic [7:0]         err_addr;
  logic [7:0]         err_tick;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  snn_aer_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_addr   (ev_addr),
    .tick      (tick),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_syn   (out_syn),
    .err_addr  (err_addr),
    .err_tick  (err_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input int b, input int n);
    int budget = 0;
    ev_valid     = 1'b1;
    ev_addr.block  = BLK_W'(b);
    ev_addr.neuron = NRN_W'(n);
    while (ev_ready !== 1'b1 && budget < 50) begin
      step();
      budget++;
    end
    check("ev_accept", 32'(ev_ready), 32'd1);
    step();
    ev_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int budget = 0;
    while (out_valid !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  // Drain one timestep with out_ready high; e0/e1 are the expected block vectors (n2..n0).
  task automatic collect(input string tag, input logic [N*SYN_W-1:0] e0,
                         input logic [N*SYN_W-1:0] e1);
    out_ready = 1'b1;
    wait_valid({tag, "_v0"});
    check({tag, "_blk0"}, 32'(out_block), 32'd0);
    check({tag, "_syn0"}, 32'(out_syn), 32'(e0));
    step();
    wait_valid({tag, "_v1"});
    check({tag, "_blk1"}, 32'(out_block), 32'd1);
    check({tag, "_syn1"}, 32'(out_syn), 32'(e1));
    step();
    out_ready = 1'b0;
    check({tag, "_done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int accepted;
    reset    = 1'b1;
    ev_valid = 1'b0;
    ev_addr  = '0;
    tick     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_ev_ready", 32'(ev_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_block", 32'(out_block), 32'd0);
    check("rst_out_syn", 32'(out_syn), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    check("rst_err_tick", 32'(err_tick), 32'd0);
    reset = 1'b0;
    step();
    check("rel_ev_ready", 32'(ev_ready), 32'd1);

    // Basic accumulation: (0,1) x3, (1,2) x1.
    send_ev(0, 1);
    send_ev(0, 1);
    send_ev(0, 1);
    send_ev(1, 2);
    pulse_tick();
`ifndef SNN_AER_FIFO_EN
    check("tick_latency", 32'(out_valid), 32'd1);
`endif
    collect("basic", 12'h030, 12'h100);
    check("basic_err_addr", 32'(err_addr), 32'd0);
    check("basic_err_tick", 32'(err_tick), 32'd0);

    // Saturation at 15 after 20 events.
    for (int i = 0; i < 20; i++) send_ev(1, 0);
    pulse_tick();
    collect("sat", 12'h000, 12'h00F);

    // Out-of-range neuron index; block 2 is not encodable with BLK_W=1, so neuron 3 is used twice.
    send_ev(0, 3);
    send_ev(1, 3);
    pulse_tick();
    collect("drop", 12'h000, 12'h000);
    check("drop_err_addr", 32'(err_addr), 32'd2);

`ifndef SNN_AER_FIFO_EN
    // Stall the flush: outputs hold, a tick in FLUSH is counted and ignored, events keep landing.
    send_ev(0, 2);
    pulse_tick();
    check("hold_lat", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_block", 32'(out_block), 32'd0);
      check("hold_syn", 32'(out_syn), 32'h100);
      if (i == 1)      pulse_tick();
      else if (i == 2) send_ev(0, 0);
      else             step();
    end
    check("hold_err_tick", 32'(err_tick), 32'd1);
    collect("hold", 12'h100, 12'h000);
    pulse_tick();
    collect("after", 12'h001, 12'h000);
`else
    // Decoder stalled in FLUSH: FIFO takes 4 events, then ev_ready drops.
    pulse_tick();
    wait_valid("fifo_v");
    ev_valid       = 1'b1;
    ev_addr.block  = BLK_W'(0);
    ev_addr.neuron = NRN_W'(0);
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (ev_ready === 1'b1) accepted++;
      step();
    end
    check("fifo_accepted", 32'(accepted), 32'd4);
    check("fifo_ready_low", 32'(ev_ready), 32'd0);
    ev_valid = 1'b0;
    collect("fifo_flush", 12'h000, 12'h000);
    send_ev(0, 0);
    send_ev(0, 0);
    pulse_tick();
    collect("fifo_cnt", 12'h006, 12'h000);
    check("fifo_err_tick", 32'(err_tick), 32'd0);
`endif

    // Event in the tick cycle belongs to the ending step; one cycle later belongs to the next.
    ev_valid       = 1'b1;
    ev_addr.block  = BLK_W'(1);
    ev_addr.neuron = NRN_W'(1);
    tick           = 1'b1;
    check("same_ready", 32'(ev_ready), 32'd1);
    step();
    tick = 1'b0;
    check("next_ready", 32'(ev_ready), 32'd1);
    step();
    ev_valid = 1'b0;
    collect("same", 12'h000, 12'h010);
    pulse_tick();
    collect("next", 12'h000, 12'h010);

    // Reset in the middle of a flush.
    send_ev(0, 0);
    send_ev(0, 0);
    pulse_tick();
    wait_valid("mid_v");
    check("mid_syn", 32'(out_syn), 32'h002);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(ev_ready), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("mid_rel_ready", 32'(ev_ready), 32'd1);
    check("mid_err_addr", 32'(err_addr), 32'd0);
    pulse_tick();
    collect("post_rst", 12'h000, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
